// File: rtl/obi_ext_slave_guard.sv
// ============================================================================
//  Module   : obi_ext_slave_guard (with obi_pkg)
//  Brief    : OBI slave-port guard in front of an off-subsystem slave. Tracks
//             the single outstanding transaction, answers locally with a
//             poison value on response timeout, absorbs late responses and
//             quarantines a slave that never answers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage : obi_pkg

module obi_ext_slave_guard
   import obi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hBADCAB1E,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  obi_req_t   bus_req_i,
   output obi_resp_t  bus_resp_o,
   output obi_req_t   slave_req_o,
   input  obi_resp_t  slave_resp_i,
   output logic       timeout_o,
   output logic       dead_o,
   input  logic       timeout_clr_i,
   output logic [7:0] timeout_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_R  = 3'd1,
      S_TO_RESP = 3'd2,
      S_DRAIN   = 3'd3,
      S_DEAD    = 3'd4,
      S_DEAD_R  = 3'd5
   } state_t;

   // The counter is compared before it increments, so the limit test fires
   // on the cycle in which the count would reach TIMEOUT_CYCLES-1.
   localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(TIMEOUT_CYCLES - 2);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;
   logic             r_dead;
   logic [7:0]       r_to_cnt;
   logic             r_clr_pend;

   logic             w_limit;
   logic             w_dead_set;

   assign w_limit    = (r_cnt == c_LIMIT);
   assign w_dead_set = (r_state == S_DRAIN) && !slave_resp_i.rvalid && w_limit;

   // Transaction tracking FSM, timeout counter and sticky status flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_timeout  <= 1'b0;
         r_dead     <= 1'b0;
         r_to_cnt   <= 8'd0;
         r_clr_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus_req_i.req && slave_resp_i.gnt) begin
                  r_state <= S_WAIT_R;
                  r_cnt   <= '0;
               end
            end
            S_WAIT_R: begin
               if (slave_resp_i.rvalid) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_limit) begin
                     r_state <= S_TO_RESP;
                  end
               end
            end
            S_TO_RESP: begin
               // A slave response landing exactly on the poison cycle is
               // treated as the late response and absorbed here.
               r_cnt   <= '0;
               r_state <= slave_resp_i.rvalid ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
               if (slave_resp_i.rvalid) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_limit) begin
                     r_state <= S_DEAD;
                  end
               end
            end
            S_DEAD: begin
               // A locally granted request must still be answered, so a
               // clear arriving together with it is remembered for DEAD_R.
               if (bus_req_i.req) begin
                  r_state    <= S_DEAD_R;
                  r_clr_pend <= timeout_clr_i;
               end else if (timeout_clr_i) begin
                  r_state <= S_IDLE;
               end
            end
            S_DEAD_R: begin
               r_clr_pend <= 1'b0;
               r_state    <= (timeout_clr_i || r_clr_pend) ? S_IDLE : S_DEAD;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Setting the timeout flag wins over a same-cycle clear; the count
         // then restarts at one to reflect the timeout just taken.
         if (r_state == S_TO_RESP) begin
            r_timeout <= 1'b1;
            if (timeout_clr_i) begin
               r_to_cnt <= 8'd1;
            end else if (r_to_cnt != 8'hFF) begin
               r_to_cnt <= r_to_cnt + 8'd1;
            end
         end else if (timeout_clr_i) begin
            r_timeout <= 1'b0;
            r_to_cnt  <= 8'd0;
         end

         if (w_dead_set) begin
            r_dead <= 1'b1;
         end else if (timeout_clr_i) begin
            r_dead <= 1'b0;
         end
      end
   end

   // Per-state steering of the bus and slave handshakes; everything is held
   // at zero while reset is asserted, independent of the clock.
   always_comb begin
      bus_resp_o  = '0;
      slave_req_o = '0;
      if (rst_ni) begin
         case (r_state)
            S_IDLE: begin
               slave_req_o    = bus_req_i;
               bus_resp_o.gnt = slave_resp_i.gnt;
            end
            S_WAIT_R: begin
               bus_resp_o.rvalid = slave_resp_i.rvalid;
               bus_resp_o.rdata  = slave_resp_i.rvalid ? slave_resp_i.rdata : 32'h0;
            end
            S_TO_RESP, S_DEAD_R: begin
               bus_resp_o.rvalid = 1'b1;
               bus_resp_o.rdata  = ERR_RDATA;
            end
            S_DEAD: begin
               bus_resp_o.gnt = bus_req_i.req;
            end
            default: begin
            end
         endcase
      end
   end

   assign timeout_o     = r_timeout;
   assign dead_o        = r_dead;
   assign timeout_cnt_o = r_to_cnt;

endmodule : obi_ext_slave_guard

`default_nettype wire

// File: tb/tb_obi_ext_slave_guard.sv
// ============================================================================
//  Module   : tb_obi_ext_slave_guard
//  Brief    : Self-checking bench for obi_ext_slave_guard with a behavioural
//             external slave and an expected-response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_ext_slave_guard;
   import obi_pkg::*;

   localparam int unsigned TO  = 8;
   localparam logic [31:0] ERR = 32'hBADCAB1E;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   obi_req_t   bus_req_i;
   obi_resp_t  bus_resp_o;
   obi_req_t   slave_req_o;
   obi_resp_t  slave_resp_i;
   logic       timeout_o;
   logic       dead_o;
   logic       timeout_clr_i;
   logic [7:0] timeout_cnt_o;

   obi_ext_slave_guard #(
      .TIMEOUT_CYCLES (TO),
      .ERR_RDATA      (ERR)
   ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .bus_req_i     (bus_req_i),
      .bus_resp_o    (bus_resp_o),
      .slave_req_o   (slave_req_o),
      .slave_resp_i  (slave_resp_i),
      .timeout_o     (timeout_o),
      .dead_o        (dead_o),
      .timeout_clr_i (timeout_clr_i),
      .timeout_cnt_o (timeout_cnt_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- behavioural external slave ----------------
   int          sl_gnt_wait = 0;   // cycles req is held before gnt
   int          sl_rsp_lat  = 1;   // cycles after gnt to rvalid, 0 = never
   logic [31:0] sl_rdata    = 32'h0;
   logic        sl_rvalid   = 1'b0;
   logic [31:0] sl_rv_data  = 32'h0;
   int          reqcnt      = 0;

   assign slave_resp_i = '{gnt:    (slave_req_o.req && (reqcnt >= sl_gnt_wait)),
                           rvalid: sl_rvalid,
                           rdata:  sl_rv_data};

   initial begin : slave_model
      logic        hs, req_now, pend;
      int          cnt, lat;
      logic [31:0] d;
      pend = 1'b0; cnt = 0; lat = 0; d = 32'h0;
      forever begin
         @(negedge clk);
         hs      = slave_req_o.req && slave_resp_i.gnt;
         req_now = slave_req_o.req;
         @(posedge clk); #1;
         sl_rvalid  = 1'b0;
         sl_rv_data = 32'h0;
         if (hs) begin
            pend = 1'b1; cnt = 0; lat = sl_rsp_lat; d = sl_rdata; reqcnt = 0;
         end else if (req_now) begin
            reqcnt++;
         end else begin
            reqcnt = 0;
         end
         if (pend) begin
            cnt++;
            if (lat > 0 && cnt == lat) begin
               sl_rvalid  = 1'b1;
               sl_rv_data = d;
               pend       = 1'b0;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] rdata;
      int          lat;
   } exp_t;
   exp_t q[$];
   int   gnt_cyc = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus_req_i.req && bus_resp_o.gnt) gnt_cyc = cyc;
         if (bus_resp_o.rvalid) begin
            if (q.size() == 0) begin
               chk("spurious_rvalid", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("rdata", bus_resp_o.rdata, e.rdata);
               chk("rsp_latency", 32'(cyc - gnt_cyc), 32'(e.lat));
            end
         end else begin
            chk("rdata_idle_zero", bus_resp_o.rdata, 32'h0);
         end
      end
   end

   // ---------------- bus master ----------------
   task automatic bus_txn(input logic [31:0] addr, input logic [31:0] exp_d,
                          input int exp_lat, input bit sreq_on);
      exp_t e;
      bit   got;
      e.rdata = exp_d;
      e.lat   = exp_lat;
      @(posedge clk); #1;
      bus_req_i = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: addr, wdata: 32'h0};
      q.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (bus_resp_o.gnt) begin
            got = 1'b1;
            if (sreq_on) chk("sreq_addr_at_gnt", slave_req_o.addr, addr);
            else         chk("sreq_blocked", 32'(slave_req_o.req), 32'd0);
         end else if (sreq_on && slave_req_o.req) begin
            chk("sreq_stable", slave_req_o.addr, addr);
         end
      end
      if (!got) chk("gnt_wait_expired", 32'd0, 32'd1);
      @(posedge clk); #1;
      bus_req_i = '0;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         chk("rsp_wait_expired", 32'(q.size()), 32'd0);
         q.delete();
      end
   endtask

   task automatic clr_pulse();
      @(posedge clk); #1;
      timeout_clr_i = 1'b1;
      @(posedge clk); #1;
      timeout_clr_i = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      bit seen;
      bus_req_i     = '0;
      timeout_clr_i = 1'b0;

      // Reset state, during and after reset.
      #2;
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      chk("rst_cnt", 32'(timeout_cnt_o), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_dead", 32'(dead_o), 32'd0);
      chk("post_rst_gnt", 32'(bus_resp_o.gnt), 32'd0);
      chk("post_rst_sreq", 32'(slave_req_o.req), 32'd0);

      // Normal read.
      sl_gnt_wait = 0; sl_rsp_lat = 3; sl_rdata = 32'h12345678;
      bus_txn(32'h0000_0040, 32'h12345678, 3, 1'b1);
      chk("normal_timeout", 32'(timeout_o), 32'd0);

      // Delayed grant.
      sl_gnt_wait = 10; sl_rsp_lat = 2; sl_rdata = 32'h5555_AAAA;
      bus_txn(32'h0000_0044, 32'h5555_AAAA, 2, 1'b1);
      chk("dly_gnt_timeout", 32'(timeout_o), 32'd0);
      sl_gnt_wait = 0;

      // Response exactly on the last allowed cycle.
      sl_rsp_lat = TO - 1; sl_rdata = 32'h7777_AAAA;
      bus_txn(32'h0000_0080, 32'h7777_AAAA, TO - 1, 1'b1);
      @(negedge clk);
      chk("boundary_timeout", 32'(timeout_o), 32'd0);
      chk("boundary_cnt", 32'(timeout_cnt_o), 32'd0);

      // Response timeout with a late response 3 cycles after the poison.
      sl_rsp_lat = TO + 3; sl_rdata = 32'hDEAD_0001;
      bus_txn(32'h0000_0100, ERR, TO, 1'b1);
      @(negedge clk);
      chk("to_flag", 32'(timeout_o), 32'd1);
      chk("to_cnt", 32'(timeout_cnt_o), 32'd1);
      sl_rsp_lat = 2; sl_rdata = 32'hCAFE_0002;
      bus_txn(32'h0000_0104, 32'hCAFE_0002, 2, 1'b1);

      clr_pulse();
      @(negedge clk);
      chk("clr_timeout", 32'(timeout_o), 32'd0);
      chk("clr_cnt", 32'(timeout_cnt_o), 32'd0);

      // Dead slave.
      sl_rsp_lat = 0;
      bus_txn(32'h0000_0200, ERR, TO, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (dead_o) seen = 1'b1;
      end
      chk("dead_latency", 32'(cyc - gnt_cyc), 32'(2 * TO));
      for (int k = 0; k < 3; k++) bus_txn(32'h0000_0300 + 32'(4 * k), ERR, 1, 1'b0);
      @(negedge clk);
      chk("dead_cnt_held", 32'(timeout_cnt_o), 32'd1);
      chk("dead_flag", 32'(dead_o), 32'd1);
      clr_pulse();
      @(negedge clk);
      chk("dead_clr_dead", 32'(dead_o), 32'd0);
      chk("dead_clr_timeout", 32'(timeout_o), 32'd0);
      chk("dead_clr_cnt", 32'(timeout_cnt_o), 32'd0);
      sl_rsp_lat = 1; sl_rdata = 32'h0BAD_F00D;
      bus_txn(32'h0000_0400, 32'h0BAD_F00D, 1, 1'b1);

      // Saturation of the timeout count; late response lands in DRAIN.
      sl_rsp_lat = TO + 1;
      for (int k = 0; k < 300; k++) bus_txn(32'h0000_1000, ERR, TO, 1'b1);
      repeat (4) @(negedge clk);
      chk("sat_cnt", 32'(timeout_cnt_o), 32'd255);
      chk("sat_flag", 32'(timeout_o), 32'd1);
      chk("sat_not_dead", 32'(dead_o), 32'd0);

      // Asynchronous reset while waiting for a response.
      sl_rsp_lat = 0;
      @(posedge clk); #1;
      bus_req_i = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0000_0500, wdata: 32'h0};
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus_resp_o.gnt) seen = 1'b1;
      end
      chk("arst_setup_gnt", 32'(seen), 32'd1);
      @(posedge clk); #1;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_timeout", 32'(timeout_o), 32'd0);
      chk("arst_cnt", 32'(timeout_cnt_o), 32'd0);
      chk("arst_sreq", 32'(slave_req_o.req), 32'd0);
      chk("arst_gnt", 32'(bus_resp_o.gnt), 32'd0);
      chk("arst_rvalid", 32'(bus_resp_o.rvalid), 32'd0);
      bus_req_i = '0;
      @(negedge clk);
      rst_n = 1'b1;
      sl_rsp_lat = 2; sl_rdata = 32'h600D_0003;
      bus_txn(32'h0000_0600, 32'h600D_0003, 2, 1'b1);
      chk("arst_after_timeout", 32'(timeout_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_obi_ext_slave_guard

`default_nettype wire
